// File: rtl/gcd_binary_param_pkg.sv
// Shared state encoding for the binary-GCD engine.
// State bit order is {q_Done, q_Mult, q_Sub, q_I}.
package gcd_pkg;
  typedef logic [3:0] state_t;

  localparam state_t INI  = 4'b0001;
  localparam state_t SUB  = 4'b0010;
  localparam state_t MULT = 4'b0100;
  localparam state_t DONE = 4'b1000;
endpackage

// File: rtl/gcd_binary_param_step.sv
// One Stein reduction step: next A, B, K for the SUB state plus the A==B flag.
module gcd_step #(
  parameter int W  = 8,
  parameter int KW = 4
) (
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [KW-1:0] k,
  output logic [W-1:0]  a_nxt,
  output logic [W-1:0]  b_nxt,
  output logic [KW-1:0] k_nxt,
  output logic          eq
);
  always_comb begin
    a_nxt = a;
    b_nxt = b;
    k_nxt = k;
    eq    = (a == b);
    if (!eq) begin
      if (a < b) begin
        a_nxt = b;
        b_nxt = a;
      end else if (a[0] && b[0]) begin
        a_nxt = a - b;
      end else if (!a[0] && !b[0]) begin
        a_nxt = a >> 1;
        b_nxt = b >> 1;
        k_nxt = k + 1'b1;
      end else if (!a[0]) begin
        a_nxt = a >> 1;
      end else begin
        b_nxt = b >> 1;
      end
    end
  end
endmodule

// File: rtl/gcd_binary_param.sv
// Parametrised binary-GCD engine with Start/Ack handshake and CEN single-step.
// Optional macro GCD_CYCLE_COUNT_EN adds a saturating 16-bit Cycles output.
module gcd_binary_param
  import gcd_pkg::*;
#(
  parameter int W             = 8,
  parameter int RESTORE_SHIFT = 0,
  parameter int KW            = $clog2(W) + 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          CEN,
  input  logic          Start,
  input  logic          Ack,
  input  logic [W-1:0]  Ain,
  input  logic [W-1:0]  Bin,
  output logic [W-1:0]  A,
  output logic [W-1:0]  B,
  output logic [W-1:0]  Gcd,
  output logic [KW-1:0] K,
  output logic          Zero,
`ifdef GCD_CYCLE_COUNT_EN
  output logic [15:0]   Cycles,
`endif
  output logic          q_I,
  output logic          q_Sub,
  output logic          q_Mult,
  output logic          q_Done
);
  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d, b_q, b_d, gcd_q, gcd_d;
  logic [KW-1:0] k_q, k_d;
  logic          zero_q, zero_d;

  logic [W-1:0]  step_a, step_b;
  logic [KW-1:0] step_k;
  logic          step_eq;

  gcd_step #(.W(W), .KW(KW)) u_step (
    .a(a_q), .b(b_q), .k(k_q),
    .a_nxt(step_a), .b_nxt(step_b), .k_nxt(step_k), .eq(step_eq)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    k_d     = k_q;
    zero_d  = zero_q;
    case (state_q)
      INI: begin
        a_d    = Ain;
        b_d    = Bin;
        k_d    = '0;
        gcd_d  = '0;
        zero_d = 1'b0;
        if (Start) begin
          if (Ain == '0 || Bin == '0) begin
            state_d = DONE;
            gcd_d   = Ain | Bin;
            zero_d  = 1'b1;
          end else begin
            state_d = SUB;
          end
        end
      end
      SUB: if (CEN) begin
        a_d = step_a;
        b_d = step_b;
        k_d = step_k;
        if (step_eq) begin
          gcd_d   = a_q;
          state_d = (k_q == '0) ? DONE : MULT;
        end
      end
      // MULT is only entered with K >= 1, so the doubling path ends at K==1.
      MULT: if (CEN) begin
        if (RESTORE_SHIFT != 0) begin
          gcd_d   = gcd_q << k_q;
          k_d     = '0;
          state_d = DONE;
        end else begin
          gcd_d = gcd_q << 1;
          k_d   = k_q - 1'b1;
          if (k_q == KW'(1)) state_d = DONE;
        end
      end
      DONE: if (Ack) state_d = INI;
      default: state_d = INI;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= INI;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      k_q     <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gcd_q   <= gcd_d;
      k_q     <= k_d;
      zero_q  <= zero_d;
    end
  end

`ifdef GCD_CYCLE_COUNT_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == INI)
      cyc_d = '0;
    else if (CEN && (state_q == SUB || state_q == MULT) && cyc_q != 16'hFFFF)
      cyc_d = cyc_q + 16'd1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end

  assign Cycles = cyc_q;
`endif

  assign A    = a_q;
  assign B    = b_q;
  assign Gcd  = gcd_q;
  assign K    = k_q;
  assign Zero = zero_q;
  assign {q_Done, q_Mult, q_Sub, q_I} = state_q;
endmodule

// File: tb/tb_gcd_binary_param.sv
// Bench for gcd_binary_param: W=8 doubling restore and W=16 barrel restore side by side,
// checked against a Euclid reference through per-instance scoreboards.
module tb_gcd_binary_param;
  logic Clk = 1'b0;
  logic Reset, CEN, Start, Ack;

  logic [7:0]  ain0, bin0, a0, b0, g0;
  logic [3:0]  k0;
  logic        z0, qi0, qs0, qm0, qd0;
  logic [15:0] ain1, bin1, a1, b1, g1;
  logic [4:0]  k1;
  logic        z1, qi1, qs1, qm1, qd1;
`ifdef GCD_CYCLE_COUNT_EN
  logic [15:0] cyc0, cyc1;
`endif

  always #5 Clk = ~Clk;

  gcd_binary_param #(.W(8), .RESTORE_SHIFT(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .CEN(CEN), .Start(Start), .Ack(Ack),
    .Ain(ain0), .Bin(bin0), .A(a0), .B(b0), .Gcd(g0), .K(k0), .Zero(z0),
`ifdef GCD_CYCLE_COUNT_EN
    .Cycles(cyc0),
`endif
    .q_I(qi0), .q_Sub(qs0), .q_Mult(qm0), .q_Done(qd0)
  );

  gcd_binary_param #(.W(16), .RESTORE_SHIFT(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .CEN(CEN), .Start(Start), .Ack(Ack),
    .Ain(ain1), .Bin(bin1), .A(a1), .B(b1), .Gcd(g1), .K(k1), .Zero(z1),
`ifdef GCD_CYCLE_COUNT_EN
    .Cycles(cyc1),
`endif
    .q_I(qi1), .q_Sub(qs1), .q_Mult(qm1), .q_Done(qd1)
  );

  int errors = 0;
  int checks = 0;

  typedef struct { logic [15:0] g; logic z; } exp_t;
  exp_t sb0[$];
  exp_t sb1[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_gcd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic go(input logic [15:0] a, input logic [15:0] b);
    ain0 = a[7:0];
    bin0 = b[7:0];
    ain1 = a;
    bin1 = b;
    sb0.push_back('{g: ref_gcd({8'h00, a[7:0]}, {8'h00, b[7:0]}), z: (a[7:0] == 0 || b[7:0] == 0)});
    sb1.push_back('{g: ref_gcd(a, b), z: (a == 0 || b == 0)});
    Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic finish(output int cyc, output int s0, output int m0, output int m1);
    exp_t e;
    cyc = 0; s0 = 0; m0 = 0; m1 = 0;
    while (!(qd0 && qd1) && cyc < 300) begin
      s0 += int'(qs0);
      m0 += int'(qm0);
      m1 += int'(qm1);
      @(posedge Clk); #1;
      cyc++;
    end
    check("done_timeout", {31'd0, qd0 && qd1}, 1);
    if (sb0.size() > 0) begin
      e = sb0.pop_front();
      check("gcd_w8", {24'd0, g0}, {16'd0, e.g});
      check("zero_w8", {31'd0, z0}, {31'd0, e.z});
      check("k_w8", {28'd0, k0}, 0);
    end
    if (sb1.size() > 0) begin
      e = sb1.pop_front();
      check("gcd_w16", {16'd0, g1}, {16'd0, e.g});
      check("zero_w16", {31'd0, z1}, {31'd0, e.z});
      check("k_w16", {27'd0, k1}, 0);
    end
  endtask

  task automatic ack();
    Ack = 1'b1;
    @(posedge Clk); #1;
    Ack = 1'b0;
    check("ini_after_ack", {30'd0, qi1, qi0}, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, s0, m0, m1;
    Reset = 1'b1; CEN = 1'b1; Start = 1'b0; Ack = 1'b0;
    ain0 = 8'd0; bin0 = 8'd0; ain1 = 16'd0; bin1 = 16'd0;
    #12;
    check("reset_state", {28'd0, qd0, qm0, qs0, qi0}, 4'b0001);
    check("reset_outs", {g0, a0, b0, k0, 3'd0, z0}, 0);
    @(negedge Clk) Reset = 1'b0;

    // Ack in INI does nothing; INI keeps loading operands.
    ain0 = 8'd3; bin0 = 8'd4;
    Ack = 1'b1;
    @(posedge Clk); #1;
    Ack = 1'b0;
    check("ack_in_ini", {31'd0, qi0}, 1);
    check("ini_load_a", {24'd0, a0}, 3);

    go(36, 24);
    finish(cyc, s0, m0, m1);
    check("sub_cycles_36_24", s0, 6);
    check("mult_cycles_w8", m0, 2);
    check("mult_cycles_w16", m1, 1);
`ifdef GCD_CYCLE_COUNT_EN
    check("cycles_w8", {16'd0, cyc0}, 8);
    check("cycles_w16", {16'd0, cyc1}, 7);
`endif
    ack();

    go(0, 5);
    finish(cyc, s0, m0, m1);
    check("zero_latency", cyc, 0);
    ack();

    go(0, 0);
    finish(cyc, s0, m0, m1);
    ack();

    go(65535, 255);
    finish(cyc, s0, m0, m1);
    check("no_mult_w16", m1, 0);
    ack();

    go(7, 7);
    finish(cyc, s0, m0, m1);
    check("equal_one_sub", s0, 1);
    ack();

    // Freeze mid-SUB after two steps: 36,24 -> 18,12 -> 9,6 with K=2.
    go(36, 24);
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    CEN = 1'b0;
    repeat (5) begin @(posedge Clk); #1; end
    check("freeze_a", {24'd0, a0}, 9);
    check("freeze_b", {24'd0, b0}, 6);
    check("freeze_k", {28'd0, k0}, 2);
    check("freeze_state", {28'd0, qd0, qm0, qs0, qi0}, 4'b0010);
    check("freeze_w16", {a1, b1}, {16'd9, 16'd6});
    CEN = 1'b1;
    finish(cyc, s0, m0, m1);
    check("resume_mult_w8", m0, 2);

    // Start in DONE is ignored; Start held through Ack restarts.
    Start = 1'b1;
    @(posedge Clk); #1;
    check("start_in_done", {31'd0, qd0}, 1);
    check("done_hold_gcd", {24'd0, g0}, 12);
    Ack = 1'b1;
    @(posedge Clk); #1;
    Ack = 1'b0;
    check("ack_to_ini", {31'd0, qi0}, 1);
    @(posedge Clk); #1;
    Start = 1'b0;
    check("restart_sub", {31'd0, qs0}, 1);

    // Asynchronous reset while in MULT.
    cyc = 0;
    while (!qm0 && cyc < 50) begin @(posedge Clk); #1; cyc++; end
    check("reach_mult", {31'd0, qm0}, 1);
    #2 Reset = 1'b1;
    #1;
    check("async_reset_state", {28'd0, qd0, qm0, qs0, qi0}, 4'b0001);
    check("async_reset_w8", {g0, a0, b0, k0, 3'd0, z0}, 0);
    check("async_reset_w16", {g1, a1}, 0);
    @(negedge Clk) Reset = 1'b0;
    sb0.delete();
    sb1.delete();

    go(12, 18);
    finish(cyc, s0, m0, m1);
    ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gcd_binary_param.md
# gcd_binary_param

Parametrised binary-GCD (Stein's algorithm) engine with Start/Ack handshake and single-step clock enable. It generalises the 8-bit calculator core to any operand width, resolves zero operands explicitly, and offers a one-cycle power-of-two restore mode. It sits between the board I/O layer (switch and button inputs, SSD/LED display mux) and exposes its one-hot state for display.

## Interface
- W, 8: operand and result width in bits, ≥ 2.
- RESTORE_SHIFT, 0: restore mode. 0 = one doubling per enabled cycle; 1 = single-cycle barrel shift.
- KW, $clog2(W)+1: width of the factor-of-2 counter K.
- Clk  in  1  clock. Reset is asynchronous, active-high; the clock is Clk.
- Reset  in  1  asynchronous, active-high.
- CEN  in  1  step enable for SUB and MULT; ignored in INI and DONE.
- Start  in  1  level; sampled only in INI.
- Ack  in  1  level; sampled only in DONE.
- Ain, Bin  in  W  operands; captured in INI.
- A, B  out  W  working registers.
- Gcd  out  W  result; valid in DONE.
- K  out  KW  count of shared factors of 2.
- Zero  out  1  set in DONE when at least one operand was 0.
- q_I, q_Sub, q_Mult, q_Done  out  1 each  one-hot state.

## Operation
- Reset: state INI. A, B, Gcd, K and Zero = 0.
- INI, every cycle:
  - A←Ain, B←Bin, K←0, Gcd←0, Zero←0.
  - If Start and either operand is 0: go directly to DONE with Gcd←Ain|Bin and Zero←1. gcd(0,0) = 0.
  - If Start and both operands are nonzero: go to SUB.
- SUB, only when CEN=1, priority order:
  1. A==B: Gcd←A. Next state is DONE if K==0, else MULT.
  2. A<B: swap A and B.
  3. A>B, both odd: A←A−B.
  4. A>B, both even: A←A>>1, B←B>>1, K←K+1.
  5. A>B, mixed parity: halve only the even operand.
- MULT, only when CEN=1:
  - RESTORE_SHIFT=0: Gcd←Gcd<<1, K←K−1. When K==1, go to DONE.
  - RESTORE_SHIFT=1: Gcd←Gcd<<K, K←0, go to DONE.
- DONE: all registers hold. Ack→INI. Start is ignored.
- Arithmetic rules:
  - The subtraction A−B only occurs with A>B, so it never wraps.
  - The shift result is truncated to W bits, which cannot overflow because Gcd ≤ min(Ain,Bin).
  - K never exceeds W−1.
- Any undefined state encoding moves to INI on the next edge.

## Timing
- Start is sampled at edge n; the state is SUB or DONE after edge n.
- Each SUB or MULT action takes exactly one edge with CEN=1. CEN=0 freezes all registers and the state.
- Outputs are fully registered; there is no combinational path from any input to any output.
- Ack is sampled at edge m in DONE; the state is INI after edge m, and Ain/Bin are reloaded from edge m+1.
- Asserting Reset during any state returns all outputs to their reset values immediately, without waiting for a clock edge.
- Start held high through DONE and Ack starts a new computation on the first INI edge.

## Configuration
- GCD_CYCLE_COUNT_EN defined:
  - Adds output Cycles (out, 16 bits).
  - Cleared in INI; incremented on every CEN=1 edge in SUB or MULT; saturates at 16'hFFFF; held in DONE.
  - Reset value 0.
- GCD_CYCLE_COUNT_EN undefined: the port and counter do not exist, and all other behaviour is identical.

## Structure
- Package gcd_pkg holds:
  - The one-hot state localparams INI=4'b0001, SUB=4'b0010, MULT=4'b0100, DONE=4'b1000.
  - The bit ordering {q_Done,q_Mult,q_Sub,q_I}=state.
- One combinational sub-module, gcd_step, computes the SUB next-values of A, B and K and the equal flag. The FSM and registers stay in the top module.

## Test plan
- W=8, RESTORE_SHIFT=0, Ain=36, Bin=24, CEN=1: 6 SUB cycles then 2 MULT cycles. DONE with Gcd=12, K=0, Zero=0, Cycles=8.
- Same operands with RESTORE_SHIFT=1: 1 MULT cycle, Gcd=12, Cycles=7.
- Ain=0, Bin=5: DONE one edge after Start, Gcd=5, Zero=1. Ain=Bin=0 gives Gcd=0, Zero=1.
- W=16, Ain=65535, Bin=255: Gcd=255, K=0, no MULT state visited. Ain=Bin=7: DONE after 1 SUB cycle with Gcd=7.
- Hold CEN=0 for 5 cycles mid-SUB: A, B, K and the state stay unchanged. Resuming gives the same result as uninterrupted operation.
- Assert Reset in MULT: the state is INI and all outputs are 0 before the next Clk edge. Ack in INI and Start in DONE have no effect.
